ssf_stream_ctrl: RTL and testbench

Frame sequencer and flow controller for the ssfblackbox filter core.
- Accepts signed 32-bit samples from an upstream valid/ready stream and buffers them.
- Serves them to the core whenever it requests input (req code 2'd1).
- Captures core results flagged by out_en code 2'd1 into an output buffer drained by a downstream valid/ready stream.
- Runs one frame of FRAME_LEN_W-bounded length per start pulse, with underrun/overflow detection.

---
 rtl/ssf_ctrl_pkg.sv | 21 ++
 rtl/ssf_sync_fifo.sv | 59 +++++
 rtl/ssf_stream_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_ssf_stream_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssf_ctrl_pkg.sv
// Shared definitions for the ssf stream controller: FSM state codes,
// core handshake codes and default widths/depths.
package ssf_ctrl_pkg;

    localparam int DEF_DATA_W        = 32;
    localparam int DEF_DEPTH         = 8;
    localparam int DEF_FRAME_LEN_W   = 16;
    localparam int DEF_DRAIN_TIMEOUT = 4096;

    // Controller states
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] PRIME = 3'd1;
    localparam logic [2:0] RUN   = 3'd2;
    localparam logic [2:0] DRAIN = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    // Core handshake codes; every other code is treated as idle
    localparam logic [1:0] REQ_FETCH = 2'd1;
    localparam logic [1:0] OUT_VALID = 2'd1;

endpackage

// File: rtl/ssf_sync_fifo.sv
// Synchronous first-word fall-through FIFO. A push into a full FIFO is
// accepted only when a pop happens in the same cycle (occupancy unchanged).
// rdata reads as zero while the FIFO is empty.
module ssf_sync_fifo
    import ssf_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic signed [DATA_W-1:0]   wdata,
    input  logic                       pop,
    output logic signed [DATA_W-1:0]   rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic signed [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]            wr_ptr;
    logic [AW-1:0]            rd_ptr;
    logic                     do_push;
    logic                     do_pop;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // Storage write; data is not reset
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ssf_stream_ctrl.sv
// Frame sequencer / flow controller for the ssfblackbox filter core.
// Buffers upstream samples, feeds them to the core on fetch requests,
// captures core results into a downstream output FIFO and runs one frame
// per start pulse with underrun/overflow flags.
// Optional macro SSF_CTRL_STATS_EN adds the lat_cycles latency port.
module ssf_stream_ctrl
    import ssf_ctrl_pkg::*;
#(
    parameter int DATA_W        = DEF_DATA_W,
    parameter int IN_DEPTH      = DEF_DEPTH,
    parameter int OUT_DEPTH     = DEF_DEPTH,
    parameter int FRAME_LEN_W   = DEF_FRAME_LEN_W,
    parameter int DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [FRAME_LEN_W-1:0]     frame_len,
    output logic                       busy,
    output logic                       done,
    output logic                       underrun,
    output logic                       overflow,
    input  logic                       s_valid,
    input  logic signed [DATA_W-1:0]   s_data,
    output logic                       s_ready,
    input  logic [1:0]                 bb_req,
    output logic signed [DATA_W-1:0]   bb_in,
    input  logic signed [DATA_W-1:0]   bb_out,
    input  logic [1:0]                 bb_out_en,
    output logic                       m_valid,
    output logic signed [DATA_W-1:0]   m_data,
    input  logic                       m_ready,
    output logic [FRAME_LEN_W-1:0]     in_count,
    output logic [FRAME_LEN_W-1:0]     out_count
`ifdef SSF_CTRL_STATS_EN
    ,
    output logic [FRAME_LEN_W-1:0]     lat_cycles
`endif
);
    localparam int TW = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [FRAME_LEN_W-1:0] LEN_ONE  = 1;
    localparam logic [TW-1:0]          TMR_ONE  = 1;
    localparam logic [TW-1:0]          TMR_LAST = TW'(DRAIN_TIMEOUT - 1);

    // Saturating counter increment (holds at all-ones)
    function automatic logic [FRAME_LEN_W-1:0] sat_inc(input logic [FRAME_LEN_W-1:0] v);
        return (v == '1) ? v : v + LEN_ONE;
    endfunction

    logic [2:0]                state;
    logic [FRAME_LEN_W-1:0]    len_q;
    logic [FRAME_LEN_W-1:0]    in_count_nxt;
    logic [TW-1:0]             drain_tmr;
    logic                      rdy_q;
    logic                      start_acc;
    logic                      fetch;
    logic                      cap_en;
    logic                      in_pop;
    logic                      in_full;
    logic                      in_empty;
    logic signed [DATA_W-1:0]  in_rdata;
    logic [$clog2(IN_DEPTH):0] in_level;
    logic                      out_pop;
    logic                      out_full;
    logic                      out_empty;
    logic [$clog2(OUT_DEPTH):0] out_level;
    logic                      unused_levels;

    assign unused_levels = ^{in_level, out_level};

    assign busy         = (state != IDLE);
    assign start_acc    = (state == IDLE) && start;
    assign s_ready      = rdy_q && !in_full;
    assign m_valid      = !out_empty;
    assign out_pop      = m_valid && m_ready;
    assign fetch        = (state == RUN) && (bb_req == REQ_FETCH) && (in_count < len_q);
    assign in_pop       = ((state == PRIME) || fetch) && !in_empty;
    assign in_count_nxt = fetch ? in_count + LEN_ONE : in_count;
    assign cap_en       = ((state == RUN) || (state == DRAIN)) && (bb_out_en == OUT_VALID);

    ssf_sync_fifo #(.DATA_W(DATA_W), .DEPTH(IN_DEPTH)) u_in_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (s_valid && s_ready),
        .wdata (s_data),
        .pop   (in_pop),
        .rdata (in_rdata),
        .full  (in_full),
        .empty (in_empty),
        .count (in_level)
    );

    ssf_sync_fifo #(.DATA_W(DATA_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cap_en),
        .wdata (bb_out),
        .pop   (out_pop),
        .rdata (m_data),
        .full  (out_full),
        .empty (out_empty),
        .count (out_level)
    );

    // Upstream ready comes up one cycle after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_q <= 1'b0;
        else        rdy_q <= 1'b1;
    end

    // Frame FSM: priming, sample issue, drain timer and completion pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            len_q     <= '0;
            in_count  <= '0;
            bb_in     <= '0;
            underrun  <= 1'b0;
            done      <= 1'b0;
            drain_tmr <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        in_count <= '0;
                        underrun <= 1'b0;
                        if (frame_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            len_q <= frame_len;
                            state <= PRIME;
                        end
                    end
                end
                PRIME: begin
                    // Preload the first sample so it is ready before the first request
                    if (!in_empty) begin
                        bb_in    <= in_rdata;
                        in_count <= LEN_ONE;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    drain_tmr <= '0;
                    if (fetch) begin
                        bb_in <= in_rdata;
                        if (in_empty) underrun <= 1'b1;
                    end
                    in_count <= in_count_nxt;
                    if (in_count_nxt == len_q) state <= DRAIN;
                end
                DRAIN: begin
                    if ((out_count >= len_q) || (drain_tmr == TMR_LAST)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        drain_tmr <= drain_tmr + TMR_ONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Result capture accounting; dropped results still count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_count <= '0;
            overflow  <= 1'b0;
        end else if (start_acc) begin
            out_count <= '0;
            overflow  <= 1'b0;
        end else if (cap_en) begin
            out_count <= sat_inc(out_count);
            if (out_full && !out_pop) overflow <= 1'b1;
        end
    end

`ifdef SSF_CTRL_STATS_EN
    logic lat_seen;

    // Cycles from entering RUN until the first captured result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_cycles <= '0;
            lat_seen   <= 1'b0;
        end else if (start_acc) begin
            lat_cycles <= '0;
            lat_seen   <= 1'b0;
        end else if (((state == RUN) || (state == DRAIN)) && !lat_seen) begin
            if (cap_en) lat_seen   <= 1'b1;
            else        lat_cycles <= sat_inc(lat_cycles);
        end
    end
`endif

endmodule

// File: tb/tb_ssf_stream_ctrl.sv
// Scoreboard bench for ssf_stream_ctrl: directed frames with hand-computed
// expectations; a negedge monitor pops expected m_data on each handshake.
module tb_ssf_stream_ctrl;
    localparam int DW  = 32;
    localparam int LW  = 16;
    localparam int DTO = 64;

    logic                  clk;
    logic                  rst_n;
    logic                  start;
    logic [LW-1:0]         frame_len;
    logic                  busy, done, underrun, overflow;
    logic                  s_valid;
    logic signed [DW-1:0]  s_data;
    logic                  s_ready;
    logic [1:0]            bb_req;
    logic signed [DW-1:0]  bb_in;
    logic signed [DW-1:0]  bb_out;
    logic [1:0]            bb_out_en;
    logic                  m_valid;
    logic signed [DW-1:0]  m_data;
    logic                  m_ready;
    logic [LW-1:0]         in_count, out_count;
`ifdef SSF_CTRL_STATS_EN
    logic [LW-1:0]         lat_cycles;
`endif

    int     n_checks = 0;
    int     n_pass   = 0;
    int     done_cnt = 0;
    longint exp_q[$];

    ssf_stream_ctrl #(.DRAIN_TIMEOUT(DTO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .frame_len (frame_len),
        .busy      (busy),
        .done      (done),
        .underrun  (underrun),
        .overflow  (overflow),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .bb_req    (bb_req),
        .bb_in     (bb_in),
        .bb_out    (bb_out),
        .bb_out_en (bb_out_en),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_ready   (m_ready),
        .in_count  (in_count),
        .out_count (out_count)
`ifdef SSF_CTRL_STATS_EN
        ,
        .lat_cycles(lat_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endfunction

    // Monitor: count done pulses and score every downstream handshake
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL m_data: got %0d, expected no output", m_data);
            end else begin
                chk("m_data", m_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_sample(input longint v);
        s_valid = 1'b1;
        s_data  = DW'(v);
        tick();
        s_valid = 1'b0;
    endtask

    task automatic start_frame(input int len);
        start     = 1'b1;
        frame_len = LW'(len);
        tick();
        start     = 1'b0;
    endtask

    // Core model: consume current bb_in with a fetch, optionally echo it 2 cycles later
    task automatic core_txn(input longint exp_in, input bit echo);
        logic signed [DW-1:0] v;
        chk("bb_in", bb_in, exp_in);
        v = bb_in;
        bb_req = 2'd1;
        tick();
        bb_req = 2'd0;
        tick();
        if (echo) begin
            bb_out    = v;
            bb_out_en = 2'd1;
        end
        tick();
        bb_out_en = 2'd0;
        tick();
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        while (busy && n < max_cyc) begin
            tick();
            n++;
        end
        chk("busy_clears", busy, 0);
    endtask

    initial begin
        int d0;
        int cnt;
        rst_n = 1'b0; start = 1'b0; frame_len = '0;
        s_valid = 1'b0; s_data = '0; bb_req = 2'd0; bb_out = '0;
        bb_out_en = 2'd0; m_ready = 1'b1;
        repeat (3) tick();

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_flags", {underrun, overflow}, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_bb_in", bb_in, 0);
        chk("rst_counts", {in_count, out_count}, 0);
        rst_n = 1'b1;
        #1;
        chk("s_ready_before_edge", s_ready, 0);
        tick();
        chk("s_ready_after_release", s_ready, 1);

        // Zero-length frame: immediate done, never busy
        d0 = done_cnt;
        start_frame(0);
        chk("zero_len_done", done, 1);
        chk("zero_len_busy", busy, 0);
        tick();
        chk("zero_len_done_drop", done, 0);
        chk("zero_len_done_count", done_cnt - d0, 1);

        // Frame of 4 with echoing core
        push_sample(5); push_sample(-3); push_sample(7); push_sample(100);
        exp_q.push_back(5); exp_q.push_back(-3); exp_q.push_back(7); exp_q.push_back(100);
        d0 = done_cnt;
        start_frame(4);
        tick();
        core_txn(5, 1); core_txn(-3, 1); core_txn(7, 1); core_txn(100, 1);
        wait_idle(200);
        chk("t1_done_count", done_cnt - d0, 1);
        chk("t1_underrun", underrun, 0);
        chk("t1_overflow", overflow, 0);
        chk("t1_in_count", in_count, 4);
        chk("t1_out_count", out_count, 4);
        chk("t1_scoreboard_empty", exp_q.size(), 0);

        // Underrun: only one sample for a 3-sample frame
        push_sample(11);
        d0 = done_cnt;
        start_frame(3);
        tick();
        core_txn(11, 0); core_txn(0, 0);
        chk("t2_bb_in_zero", bb_in, 0);
        chk("t2_underrun", underrun, 1);
        chk("t2_in_count", in_count, 3);
        wait_idle(200);
        chk("t2_done_count", done_cnt - d0, 1);
        chk("t2_out_count", out_count, 0);

        // Overflow: 10 results into an 8-deep output FIFO with no drain
        m_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push_sample(i);
        d0 = done_cnt;
        start_frame(10);
        tick();
        chk("t3_underrun_cleared", underrun, 0);
        for (int i = 0; i < 10; i++) begin
            bb_out = DW'(100 + i);
            bb_out_en = 2'd1;
            tick();
        end
        bb_out_en = 2'd0;
        bb_req = 2'd1;
        repeat (9) tick();
        bb_req = 2'd0;
        wait_idle(200);
        chk("t3_done_count", done_cnt - d0, 1);
        chk("t3_overflow", overflow, 1);
        chk("t3_out_count", out_count, 10);
        chk("t3_in_count", in_count, 10);
        chk("t3_m_valid", m_valid, 1);
        for (int i = 0; i < 8; i++) exp_q.push_back(100 + i);
        m_ready = 1'b1;
        cnt = 0;
        while (m_valid && cnt < 40) begin
            tick();
            cnt++;
        end
        chk("t3_m_valid_drained", m_valid, 0);
        chk("t3_scoreboard_empty", exp_q.size(), 0);

        // Drain timeout: core never produces a result
        push_sample(5); push_sample(6);
        d0 = done_cnt;
        start_frame(2);
        tick();
        bb_req = 2'd1;
        tick();
        bb_req = 2'd0;
        chk("t4_overflow_cleared", overflow, 0);
        cnt = 0;
        while (busy && !done && cnt < 1000) begin
            tick();
            cnt++;
        end
        chk("t4_drain_cycles", cnt, DTO);
        chk("t4_done", done, 1);
        chk("t4_busy_during_done", busy, 1);
        tick();
        chk("t4_busy_after_done", busy, 0);
        chk("t4_done_count", done_cnt - d0, 1);

        // Reset mid-RUN with 3 samples buffered
        push_sample(1); push_sample(2); push_sample(3); push_sample(4);
        start_frame(5);
        tick();
        tick();
        chk("t5_running", {busy, in_count}, {1'b1, 16'd1});
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_outputs", {s_ready, m_valid, underrun, overflow}, 0);
        chk("t5_rst_bb_in", bb_in, 0);
        chk("t5_rst_in_count", in_count, 0);
        tick();
        rst_n = 1'b1;
        tick();
        start_frame(1);
        repeat (3) tick();
        chk("t5_fifo_empty_prime_wait", {busy, in_count}, {1'b1, 16'd0});
        push_sample(42);
        tick();
        chk("t5_bb_in", bb_in, 42);
        exp_q.push_back(42);
        bb_out = 42;
        bb_out_en = 2'd1;
        tick();
        bb_out_en = 2'd0;
        wait_idle(200);
        chk("t5_done_count", done_cnt - d0, 1);
        chk("t5_out_count", out_count, 1);

        // Non-fetch / non-valid codes are ignored during RUN
        push_sample(10); push_sample(20); push_sample(30);
        d0 = done_cnt;
        start_frame(3);
        tick();
        bb_req = 2'd2; tick();
        bb_req = 2'd3; tick();
        bb_req = 2'd0;
        bb_out = 999; bb_out_en = 2'd2; tick();
        bb_out_en = 2'd3; tick();
        bb_out_en = 2'd0;
        tick();
        chk("t6_in_count", in_count, 1);
        chk("t6_bb_in", bb_in, 10);
        chk("t6_out_count", out_count, 0);
        chk("t6_m_valid", m_valid, 0);
        exp_q.push_back(10); exp_q.push_back(20); exp_q.push_back(30);
        core_txn(10, 1); core_txn(20, 1); core_txn(30, 1);
        wait_idle(200);
        chk("t6_done_count", done_cnt - d0, 1);
        chk("t6_flags", {underrun, overflow}, 0);
        chk("t6_scoreboard_empty", exp_q.size(), 0);

        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
